ahb2apb_bridge: RTL and testbench

//  AHB-Lite slave to APB4 master bridge, one transfer at a time.

---
 rtl/ahb_apb_pkg.sv | 37 +++
 rtl/apb_timeout_cnt.sv | 34 +++
 rtl/ahb2apb_bridge.sv | 132 +++++++++++++
 tb/tb_ahb2apb_bridge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and helpers for the AHB-Lite to APB4 bridge.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        tIDLE   = 2'b00,
        tBUSY   = 2'b01,
        tNONSEQ = 2'b10,
        tSEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        tBYTE  = 3'b000,
        tHWORD = 3'b001,
        tWORD  = 3'b010
    } hsize_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } bridge_state_t;

    // Byte lanes touched by a transfer; sizes above WORD collapse to a full word.
    function automatic logic [3:0] size2strb(input logic [2:0] hsize, input logic [1:0] addr_lsb);
        logic [3:0] strb;
        case (hsize)
            tBYTE:   strb = 4'b0001 << addr_lsb;
            tHWORD:  strb = addr_lsb[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating counter of stalled ACCESS cycles; flags the cycle that reaches the limit.
module apb_timeout_cnt #(
    parameter int P_TIMEOUT = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (P_TIMEOUT < 1) ? 1 : $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(P_TIMEOUT);

    logic [CW-1:0] cnt_r;

    // Stall counter: cleared per transfer, saturates at the limit.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The stalled cycle that would bring the count to the limit ends the access.
    assign expired = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge, one transfer in flight, all AHB/APB
// control outputs registered from the next-state decode.
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int P_AW      = 32,
    parameter int P_TIMEOUT = 0
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            ahb_hsel,
    input  logic [31:0]     ahb_haddr,
    input  logic [1:0]      ahb_htrans,
    input  logic            ahb_hwrite,
    input  logic [2:0]      ahb_hsize,
    input  logic [31:0]     ahb_hwdata,
    input  logic            ahb_hreadyin,
    output logic            ahb_hreadyout,
    output logic            ahb_hresp,
    output logic [31:0]     ahb_hrdata,
    output logic [P_AW-1:0] apb_paddr,
    output logic            apb_psel,
    output logic            apb_penable,
    output logic            apb_pwrite,
    output logic [31:0]     apb_pwdata,
    output logic [3:0]      apb_pstrb,
    input  logic [31:0]     apb_prdata,
    input  logic            apb_pready,
    input  logic            apb_pslverr
);

    bridge_state_t state_r;
    bridge_state_t state_nxt_s;
    logic          accept_s;
    logic          start_s;
    logic          stall_s;
    logic          expired_s;
    logic          rd_done_s;

    assign accept_s  = ahb_hsel && ahb_hreadyin &&
                       ((ahb_htrans == tNONSEQ) || (ahb_htrans == tSEQ));
    assign start_s   = (state_nxt_s == S_SETUP);
    assign stall_s   = (state_r == S_ACCESS) && !apb_pready;
    assign rd_done_s = (state_r == S_ACCESS) && apb_pready && !apb_pslverr && !apb_pwrite;

    generate
        if (P_TIMEOUT > 0) begin : g_timeout
            apb_timeout_cnt #(.P_TIMEOUT(P_TIMEOUT)) u_timeout_cnt (
                .aclk    (aclk),
                .areset  (areset),
                .clear   (start_s),
                .enable  (stall_s),
                .expired (expired_s)
            );
        end else begin : g_no_timeout
            assign expired_s = 1'b0;
        end
    endgenerate

    // Next-state logic; new transfers are only taken while the slave is ready.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nxt_s = S_SETUP;
                else          state_nxt_s = S_IDLE;
            end
            S_SETUP: state_nxt_s = S_ACCESS;
            S_ACCESS: begin
                if (apb_pready)     state_nxt_s = apb_pslverr ? S_ERR1 : S_RESP;
                else if (expired_s) state_nxt_s = S_ERR1;
                else                state_nxt_s = S_ACCESS;
            end
            S_RESP, S_ERR2: begin
                if (accept_s) state_nxt_s = S_SETUP;
                else          state_nxt_s = S_IDLE;
            end
            S_ERR1:  state_nxt_s = S_ERR2;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register plus control outputs decoded from the next state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r       <= S_IDLE;
            ahb_hreadyout <= 1'b1;
            ahb_hresp     <= 1'b0;
            apb_psel      <= 1'b0;
            apb_penable   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ahb_hreadyout <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_RESP) ||
                             (state_nxt_s == S_ERR2);
            ahb_hresp     <= (state_nxt_s == S_ERR1) || (state_nxt_s == S_ERR2);
            apb_psel      <= (state_nxt_s == S_SETUP) || (state_nxt_s == S_ACCESS);
            apb_penable   <= (state_nxt_s == S_ACCESS);
        end
    end

    // APB address/data latched once per transfer and held through completion.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            apb_paddr  <= '0;
            apb_pwrite <= 1'b0;
            apb_pwdata <= 32'd0;
            apb_pstrb  <= 4'b0000;
        end else if (start_s) begin
            apb_paddr  <= {ahb_haddr[P_AW-1:2], 2'b00};
            apb_pwrite <= ahb_hwrite;
            apb_pwdata <= ahb_hwdata;
            apb_pstrb  <= ahb_hwrite ? size2strb(ahb_hsize, ahb_haddr[1:0]) : 4'b0000;
        end else begin
            apb_paddr  <= apb_paddr;
            apb_pwrite <= apb_pwrite;
            apb_pwdata <= apb_pwdata;
            apb_pstrb  <= apb_pstrb;
        end
    end

    // Read data only moves on a successful read; writes and errors keep it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ahb_hrdata <= 32'd0;
        end else if (rd_done_s) begin
            ahb_hrdata <= apb_prdata;
        end else begin
            ahb_hrdata <= ahb_hrdata;
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed, table-driven bench for ahb2apb_bridge (P_TIMEOUT=4) with
// hand-written back-to-back and mid-transfer reset sequences.
module tb_ahb2apb_bridge;

    logic        aclk = 1'b0;
    logic        areset;
    logic        ahb_hsel;
    logic [31:0] ahb_haddr;
    logic [1:0]  ahb_htrans;
    logic        ahb_hwrite;
    logic [2:0]  ahb_hsize;
    logic [31:0] ahb_hwdata;
    logic        ahb_hreadyin;
    logic        ahb_hreadyout;
    logic        ahb_hresp;
    logic [31:0] ahb_hrdata;
    logic [31:0] apb_paddr;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [3:0]  apb_pstrb;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;
    assign ahb_hreadyin = ahb_hreadyout;

    ahb2apb_bridge #(.P_AW(32), .P_TIMEOUT(4)) dut (
        .aclk(aclk), .areset(areset),
        .ahb_hsel(ahb_hsel), .ahb_haddr(ahb_haddr), .ahb_htrans(ahb_htrans),
        .ahb_hwrite(ahb_hwrite), .ahb_hsize(ahb_hsize), .ahb_hwdata(ahb_hwdata),
        .ahb_hreadyin(ahb_hreadyin), .ahb_hreadyout(ahb_hreadyout),
        .ahb_hresp(ahb_hresp), .ahb_hrdata(ahb_hrdata),
        .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          low;      // ACCESS cycles with pready=0 before pready=1
        logic        err;
        logic [31:0] rdata;
        logic [31:0] paddr;
        logic [3:0]  strb;
        int          waits;
        int          acc;
        logic        resp;
        logic [31:0] hrdata;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_idle();
        ahb_hsel   = 1'b0;
        ahb_htrans = 2'b00;
    endtask

    task automatic drive_addr(input logic wr, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        ahb_hsel   = 1'b1;
        ahb_htrans = 2'b10;
        ahb_hwrite = wr;
        ahb_hsize  = size;
        ahb_haddr  = addr;
        ahb_hwdata = wdata;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int   waits = 0;
        int   acc = 0;
        logic prev_hresp = 1'b0;
        logic stable = 1'b1;
        logic done = 1'b0;
        chk($sformatf("v%0d idle ready", k), 32'(ahb_hreadyout), 32'd1);
        drive_addr(v.wr, v.size, v.addr, v.wdata);
        apb_prdata = v.rdata;
        for (int i = 1; i <= 30 && !done; i++) begin
            step();
            if (i == 1) begin
                drive_idle();
                chk($sformatf("v%0d T1 psel", k), 32'({apb_psel, apb_penable}), 32'd2);
            end else if (i == 2) begin
                chk($sformatf("v%0d T2 penable", k), 32'({apb_psel, apb_penable}), 32'd3);
            end else begin
            end
            if (apb_psel) begin
                if (apb_paddr !== v.paddr || apb_pstrb !== v.strb || apb_pwrite !== v.wr ||
                    (v.wr && apb_pwdata !== v.wdata))
                    stable = 1'b0;
            end
            if (apb_penable) acc++;
            apb_pready  = (acc > v.low);
            apb_pslverr = v.err && apb_pready;
            if (ahb_hreadyout) begin
                done = 1'b1;
            end else begin
                waits++;
                prev_hresp = ahb_hresp;
            end
        end
        chk($sformatf("v%0d completed", k), 32'(done), 32'd1);
        chk($sformatf("v%0d apb fields", k), 32'(stable), 32'd1);
        chk($sformatf("v%0d wait states", k), waits, v.waits);
        chk($sformatf("v%0d access cycles", k), acc, v.acc);
        chk($sformatf("v%0d hresp first", k), 32'(prev_hresp), 32'(v.resp));
        chk($sformatf("v%0d hresp last", k), 32'(ahb_hresp), 32'(v.resp));
        chk($sformatf("v%0d hrdata", k), ahb_hrdata, v.hrdata);
        chk($sformatf("v%0d psel off", k), 32'(apb_psel), 32'd0);
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        step();
    endtask

    initial begin
        //         wr    size    addr          wdata         low err rdata         paddr         strb     wt acc rsp hrdata
        vt[0]  = '{1'b1, 3'b010, 32'h0000_1000, 32'hCAFE_BABE, 0, 1'b0, 32'h0,        32'h0000_1000, 4'b1111, 2, 1, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,         3, 1'b0, 32'h1234_5678, 32'h0000_1000, 4'b0000, 5, 4, 1'b0, 32'h1234_5678};
        vt[2]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 1'b1, 32'h0,        32'h0000_2000, 4'b1100, 3, 1, 1'b1, 32'h1234_5678};
        vt[3]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 0, 1'b0, 32'h0,        32'h0000_3000, 4'b0010, 2, 1, 1'b0, 32'h1234_5678};
        vt[4]  = '{1'b1, 3'b000, 32'h0000_3002, 32'h00CD_0000, 0, 1'b0, 32'h0,        32'h0000_3000, 4'b0100, 2, 1, 1'b0, 32'h1234_5678};
        vt[5]  = '{1'b1, 3'b000, 32'h0000_3003, 32'hEF00_0000, 0, 1'b0, 32'h0,        32'h0000_3000, 4'b1000, 2, 1, 1'b0, 32'h1234_5678};
        vt[6]  = '{1'b1, 3'b001, 32'h0000_3000, 32'h0000_1357, 0, 1'b0, 32'h0,        32'h0000_3000, 4'b0011, 2, 1, 1'b0, 32'h1234_5678};
        vt[7]  = '{1'b0, 3'b010, 32'h0000_4008, 32'h0,         1, 1'b0, 32'hDEAD_BEEF, 32'h0000_4008, 4'b0000, 3, 2, 1'b0, 32'hDEAD_BEEF};
        vt[8]  = '{1'b0, 3'b010, 32'h0000_5004, 32'h0,         0, 1'b1, 32'h1111_1111, 32'h0000_5004, 4'b0000, 3, 1, 1'b1, 32'hDEAD_BEEF};
        vt[9]  = '{1'b0, 3'b010, 32'h0000_7000, 32'h0,        99, 1'b0, 32'h2222_2222, 32'h0000_7000, 4'b0000, 6, 4, 1'b1, 32'hDEAD_BEEF};
        vt[10] = '{1'b1, 3'b011, 32'h0000_7010, 32'hA5A5_5A5A, 0, 1'b0, 32'h0,        32'h0000_7010, 4'b1111, 2, 1, 1'b0, 32'hDEAD_BEEF};
        vt[11] = '{1'b0, 3'b000, 32'h0000_7001, 32'h0,         2, 1'b0, 32'h3333_3333, 32'h0000_7000, 4'b0000, 4, 3, 1'b0, 32'h3333_3333};

        areset = 1'b1;
        drive_idle();
        ahb_haddr = 32'd0; ahb_hwrite = 1'b0; ahb_hsize = 3'b010; ahb_hwdata = 32'd0;
        apb_prdata = 32'd0; apb_pready = 1'b0; apb_pslverr = 1'b0;
        #12;
        chk("rst hready/hresp", 32'({ahb_hreadyout, ahb_hresp}), 32'd2);
        chk("rst hrdata", ahb_hrdata, 32'd0);
        chk("rst psel/pen/pwrite", 32'({apb_psel, apb_penable, apb_pwrite}), 32'd0);
        chk("rst paddr", apb_paddr, 32'd0);
        chk("rst pwdata", apb_pwdata, 32'd0);
        chk("rst pstrb", 32'(apb_pstrb), 32'd0);
        areset = 1'b0;
        step();

        // BUSY with hsel: no transfer, zero-wait OKAY
        ahb_hsel = 1'b1; ahb_htrans = 2'b01;
        step();
        chk("busy no psel", 32'(apb_psel), 32'd0);
        chk("busy ready", 32'({ahb_hreadyout, ahb_hresp}), 32'd2);
        drive_idle();

        for (int k = 0; k < 12; k++) run_vec(k, vt[k]);

        // Back-to-back: second NONSEQ issued in the RESP cycle
        drive_addr(1'b0, 3'b010, 32'h0000_6000, 32'd0);
        apb_prdata = 32'h0BAD_F00D; apb_pready = 1'b1;
        step(); drive_idle();
        chk("b2b T1 setup", 32'({apb_psel, apb_penable}), 32'd2);
        step();
        chk("b2b T2 access", 32'({apb_psel, apb_penable}), 32'd3);
        step();
        chk("b2b T3 resp", 32'({ahb_hreadyout, ahb_hresp, apb_psel}), 32'd4);
        chk("b2b T3 hrdata", ahb_hrdata, 32'h0BAD_F00D);
        drive_addr(1'b1, 3'b010, 32'h0000_6004, 32'h55AA_55AA);
        step(); drive_idle();
        chk("b2b T4 setup", 32'({apb_psel, apb_penable, apb_pwrite, ahb_hreadyout}), 32'd10);
        chk("b2b T4 paddr", apb_paddr, 32'h0000_6004);
        chk("b2b T4 pwdata", apb_pwdata, 32'h55AA_55AA);
        step();
        chk("b2b T5 access", 32'({apb_psel, apb_penable}), 32'd3);
        step();
        chk("b2b T6 resp", 32'({ahb_hreadyout, ahb_hresp, apb_psel}), 32'd4);
        apb_pready = 1'b0;
        step();

        // Reset asserted during ACCESS
        drive_addr(1'b1, 3'b010, 32'h0000_8000, 32'h1234_ABCD);
        step(); drive_idle();
        step();
        chk("rstmid in access", 32'({apb_psel, apb_penable}), 32'd3);
        #2 areset = 1'b1;
        #1;
        chk("rstmid ctl", 32'({apb_psel, apb_penable, ahb_hreadyout, ahb_hresp}), 32'd2);
        chk("rstmid paddr", apb_paddr, 32'd0);
        chk("rstmid hrdata", ahb_hrdata, 32'd0);
        #2 areset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rstmid after %0d", i),
                32'({apb_psel, apb_penable, ahb_hreadyout, ahb_hresp}), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
